// File: rtl/mips_bus_pkg.sv
// Shared definitions for the mips_cpu_bus memory interface.
// Used by both the memory responder and the CPU bus master.
package mips_bus_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam int unsigned CNT_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_t;

  // Byte-lane merge: lane i takes new_w when be[i] is set, otherwise keeps old_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_bus_wait_ctrl.sv
// Wait-state sequencer: holds waitrequest for WAIT_STATES cycles per request,
// then emits a single-cycle accept strobe aligned with the committing edge.
module mips_bus_wait_ctrl
  import mips_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  output logic waitrequest_c_o,
  output logic accept_c_o
);

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WAIT_STATES);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req;

  // A request seen while reset is held must not stall the master.
  assign req = req_i & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    waitrequest_c_o = 1'b0;
    accept_c_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (W_CNT == '0) begin
            accept_c_o = 1'b1;
          end else begin
            waitrequest_c_o = 1'b1;
            cnt_d           = CNT_W'(1);
            state_d         = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q < W_CNT) begin
          waitrequest_c_o = 1'b1;
          cnt_d           = cnt_q + CNT_W'(1);
        end else begin
          accept_c_o = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Avalon-style memory target for the mips_cpu_bus: wait-state insertion,
// byte-enable write merging, registered reads and illegal-access reporting.
module mips_bus_mem_responder
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = RESET_VECTOR,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        error
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      idx;
  logic [IDX_W-1:0] widx;
  logic             in_range, is_zero, misaligned, conflict;
  logic             accept, mem_we, err_cond;
  logic [31:0]      readdata_q, readdata_d;
  logic             error_q, error_d;

  mips_bus_wait_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_ctrl (
    .clk             (clk),
    .rst_n           (reset),
    .req_i           (read | write),
    .waitrequest_c_o (waitrequest),
    .accept_c_o      (accept)
  );

  // Address decode; subtraction wraps in 32 bits so addresses below the base fail the range test.
  assign idx        = (address - ADDR_BASE) >> 2;
  assign widx       = idx[IDX_W-1:0];
  assign in_range   = (address >= ADDR_BASE) && (idx < 32'(DEPTH_WORDS));
  assign is_zero    = (address == 32'h0);
  assign misaligned = (address[1:0] != 2'b00);
  assign conflict   = read & write;

  // Address 0 is a silent null access; other bad accesses still handshake but flag an error.
  assign err_cond = conflict | (~is_zero & (~in_range | misaligned));
  assign mem_we   = accept & write & ~read & in_range & ~is_zero;

  always_comb begin
    readdata_d = readdata_q;
    error_d    = accept & err_cond;
    if (accept && read && !write) begin
      readdata_d = (in_range && !is_zero) ? mem_q[widx] : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
      error_q    <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      error_q    <= error_d;
    end
  end

  // Storage is deliberately not reset so an image survives a CPU reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= merge_bytes(mem_q[widx], writedata, byteenable);
  end

  assign readdata = readdata_q;
  assign error    = error_q;

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Randomized self-checking bench: three responders (0, 3 and 4 wait states)
// against a word-array reference model of the memory and its error rules.
module tb_mips_bus_mem_responder;

  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic [2:0]  rd_v, wr_v, wreq, err;
  logic [31:0] rdata [3];

  logic [31:0] mdl    [3][DEPTH];
  logic [31:0] exp_rd [3];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  mips_bus_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .write(wr_v[0]), .read(rd_v[0]),
    .waitrequest(wreq[0]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[0]), .error(err[0]));

  mips_bus_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .write(wr_v[1]), .read(rd_v[1]),
    .waitrequest(wreq[1]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[1]), .error(err[1]));

  mips_bus_mem_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(4)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .write(wr_v[2]), .read(rd_v[2]),
    .waitrequest(wreq[2]), .writedata(writedata), .byteenable(byteenable),
    .readdata(rdata[2]), .error(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 4);
  endfunction

  // One complete bus transfer on responder k, checked against the model.
  task automatic xfer(input int k, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    int          waits;
    logic        exp_err, inr, zero;
    logic [31:0] off;
    int unsigned w;
    zero    = (a == 32'h0);
    off     = a - BASE;
    w       = off / 4;
    inr     = (a >= BASE) && (w < DEPTH);
    exp_err = (rd && wr) || (!zero && (!inr || (a % 4) != 0));
    @(negedge clk);
    address    = a;
    writedata  = wd;
    byteenable = be;
    rd_v[k]    = rd;
    wr_v[k]    = wr;
    waits      = 0;
    #1;
    while (wreq[k] && waits < 40) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("wait_states", 32'(waits), 32'(wait_of(k)));
    @(posedge clk);
    #1;
    rd_v[k] = 1'b0;
    wr_v[k] = 1'b0;
    if (!(rd && wr)) begin
      if (rd) exp_rd[k] = (inr && !zero) ? mdl[k][w[5:0]] : 32'h0;
      if (wr && inr && !zero) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[k][w[5:0]][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    check("readdata", rdata[k], exp_rd[k]);
    check("error_pulse", 32'(err[k]), 32'(exp_err));
    @(posedge clk);
    #1;
    check("error_clear", 32'(err[k]), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    rd_v       = '0;
    wr_v       = '0;
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_readdata", rdata[k], 32'h0);
      check("rst_error", 32'(err[k]), 32'h0);
      check("rst_waitreq", 32'(wreq[k]), 32'h0);
    end
    reset = 1'b1;

    // Fill every word so the model knows all contents.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) xfer(k, 1'b0, 1'b1, BASE + 32'(4*i), $urandom, 4'hF);
    end

    // Zero-wait read, then wait-state read.
    xfer(0, 1'b0, 1'b1, 32'hBFC0002C, 32'hFF00FF00, 4'hF);
    xfer(0, 1'b1, 1'b0, 32'hBFC0002C, 32'h0, 4'h0);
    check("w0_read", rdata[0], 32'hFF00FF00);
    xfer(1, 1'b1, 1'b0, 32'hBFC00000, 32'h0, 4'h0);

    // Byte-enable merging, including the empty mask.
    xfer(0, 1'b0, 1'b1, 32'hBFC00010, 32'h11223344, 4'hF);
    xfer(0, 1'b0, 1'b1, 32'hBFC00010, 32'hAABBCCDD, 4'b0101);
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0);
    check("merge_0101", rdata[0], 32'h11BB33DD);
    xfer(0, 1'b0, 1'b1, 32'hBFC00010, 32'h55667788, 4'b0000);
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0);
    check("merge_0000", rdata[0], 32'h11BB33DD);

    // Illegal accesses and the null address.
    xfer(0, 1'b1, 1'b0, BASE + 32'(4*DEPTH), 32'h0, 4'h0);
    xfer(0, 1'b0, 1'b1, BASE + 32'(4*DEPTH), 32'hCAFEF00D, 4'hF);
    xfer(0, 1'b1, 1'b0, 32'hBFC00010, 32'h0, 4'h0);
    xfer(0, 1'b1, 1'b1, 32'hBFC00004, 32'h12345678, 4'hF);
    xfer(0, 1'b1, 1'b0, 32'hBFC00004, 32'h0, 4'h0);
    xfer(0, 1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0);
    check("null_read", rdata[0], 32'h0);

    // Request withdrawn mid-wait: no commit, no error, count restarts.
    @(negedge clk);
    address = BASE + 32'h8;
    rd_v[1] = 1'b1;
    #1;
    check("drop_wait_hi", 32'(wreq[1]), 32'h1);
    @(negedge clk);
    rd_v[1] = 1'b0;
    #1;
    check("drop_wait_lo", 32'(wreq[1]), 32'h0);
    @(posedge clk);
    #1;
    check("drop_no_err", 32'(err[1]), 32'h0);
    check("drop_readdata", rdata[1], exp_rd[1]);
    xfer(1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);

    // Reset asserted two cycles into a write's wait phase.
    @(negedge clk);
    address    = BASE + 32'd20;
    writedata  = 32'hDEADBEEF;
    byteenable = 4'hF;
    wr_v[2]    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_waitreq", 32'(wreq[2]), 32'h0);
    check("rst_mid_readdata", rdata[2], 32'h0);
    for (int k = 0; k < 3; k++) exp_rd[k] = 32'h0;
    @(negedge clk);
    wr_v[2] = 1'b0;
    reset   = 1'b1;
    xfer(2, 1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
    xfer(2, 1'b0, 1'b1, BASE + 32'd20, 32'hDEADBEEF, 4'hF);
    xfer(2, 1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
    check("post_rst_write", rdata[2], 32'hDEADBEEF);

    // Randomized mix of legal and illegal traffic.
    for (int n = 0; n < 200; n++) begin
      int          k, kind;
      int unsigned w;
      logic [31:0] a;
      logic        rd, wr;
      k    = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 9));
      w    = $urandom_range(0, DEPTH - 1);
      a    = BASE + 32'(4*w);
      rd   = 1'b0;
      wr   = 1'b0;
      if (kind < 4) begin
        rd = 1'b1;
      end else if (kind < 8) begin
        wr = 1'b1;
      end else if (kind == 8) begin
        a  = a + 32'($urandom_range(1, 3));
        rd = $urandom_range(0, 1) != 0;
        wr = !rd;
      end else begin
        case ($urandom_range(0, 3))
          0:       a = BASE + 32'(4*DEPTH) + 32'(4*$urandom_range(0, 15));
          1:       a = BASE - 32'd4;
          2:       a = 32'h0;
          default: ;
        endcase
        rd = $urandom_range(0, 1) != 0;
        wr = ($urandom_range(0, 1) != 0) || !rd;
      end
      xfer(k, rd, wr, a, $urandom, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
